// File: rtl/mix_w_loader.sv
// mix_w_loader: writer side of the mix_layer weight memory.
//
// Accepts a stream of weight elements (one per beat, valid/ready) and packs
// DATA_N of them into one RAM word. The words for W_1, W_2 and W_3 are
// written back to back at addresses 0..DEPTH-1. A start pulse begins a load.
// done/err report the load status and are held until the next start.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous reset, active HIGH despite its name
//   start    - one-cycle load request (ignored while loading)
//   s_valid  - element valid
//   s_ready  - element accepted when s_valid && s_ready
//   s_data   - weight element, N_LEN bits
//   s_last   - marks the final element of the full 3-matrix load
//   we       - RAM write enable, one-cycle pulse
//   waddr    - RAM write address
//   wdata    - packed RAM word; the first element of the word is in the MSBs
//   busy     - high while loading
//   done     - load finished
//   err      - s_last framing mismatch
//   checksum - (MIX_W_LOADER_CHECKSUM_EN only) mod-2^32 sum of accepted elements
//
// Optional feature macro: MIX_W_LOADER_CHECKSUM_EN
module mix_w_loader #(
  parameter int N_LEN   = 16,
  parameter int DATA_N  = 16,
  parameter int HID_DIM = 24,
  parameter int ADDR_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [N_LEN-1:0]        s_data,
  input  logic                    s_last,
  output logic                    we,
  output logic [ADDR_W-1:0]       waddr,
  output logic [DATA_N*N_LEN-1:0] wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err
`ifdef MIX_W_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]             checksum
`endif
);

  localparam int DEPTH  = 3 * (HID_DIM * HID_DIM / DATA_N);
  localparam int WORD_W = DATA_N * N_LEN;
  localparam int EC_W   = (DATA_N > 1) ? $clog2(DATA_N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state, state_nx;
  logic [EC_W-1:0]     elem_cnt;
  logic [ADDR_W-1:0]   word_cnt;
  logic [WORD_W-1:0]   pack, pack_nx;
  logic                hs, word_end, last_word, fin, to_done, wr_go;

  assign hs        = s_valid & s_ready;
  assign word_end  = (elem_cnt == EC_W'(DATA_N - 1));
  assign last_word = (word_cnt == ADDR_W'(DEPTH - 1));
  assign fin       = word_end & last_word;           // this beat completes the final word
  assign to_done   = hs & (s_last | fin);
  // An early s_last drops whatever is in the pack register, so only write a
  // completed word when the frame is not being cut short.
  assign wr_go     = hs & word_end & (last_word | ~s_last);

  // Shift new element in at the LSB end so the first element of a word
  // lands in the MSBs once DATA_N elements have been taken.
  generate
    if (DATA_N > 1) begin : g_shift
      assign pack_nx = {pack[WORD_W-N_LEN-1:0], s_data};
    end else begin : g_single
      assign pack_nx = s_data;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = LOAD;
      LOAD:       if (to_done) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      elem_cnt <= '0;
      word_cnt <= '0;
      pack     <= '0;
    end else begin
      // Registered from the upcoming state so they line up with state itself.
      s_ready <= (state_nx == LOAD);
      busy    <= (state_nx == LOAD);
      we      <= 1'b0;
      if (state != LOAD && start) begin
        elem_cnt <= '0;
        word_cnt <= '0;
        pack     <= '0;
        done     <= 1'b0;
        err      <= 1'b0;
      end else if (hs) begin
        pack <= pack_nx;
        if (word_end) begin
          elem_cnt <= '0;
          // Hold at the final word; LOAD exits there, so no wrap is possible.
          if (!last_word) word_cnt <= word_cnt + ADDR_W'(1);
        end else begin
          elem_cnt <= elem_cnt + EC_W'(1);
        end
        if (wr_go) begin
          we    <= 1'b1;
          waddr <= word_cnt;
          wdata <= pack_nx;
        end
        if (to_done) begin
          done <= 1'b1;
          err  <= ~(s_last & fin);
        end
      end
    end
  end

`ifdef MIX_W_LOADER_CHECKSUM_EN
  // Counts every accepted element, including those of a dropped partial word.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                        checksum <= '0;
    else if (state != LOAD && start)  checksum <= '0;
    else if (hs)                      checksum <= checksum + 32'(s_data);
  end
`endif

endmodule

// File: tb/tb_mix_w_loader.sv
module tb_mix_w_loader;

  localparam int N_LEN  = 16;
  localparam int DATA_N = 16;
  localparam int WORD_W = N_LEN * DATA_N;
  localparam int NELEM  = 1728;
  localparam int NWORD  = 108;

  logic              clk = 0;
  logic              rst_n = 1;
  logic              start = 0;
  logic              s_valid = 0;
  logic              s_ready;
  logic [N_LEN-1:0]  s_data = '0;
  logic              s_last = 0;
  logic              we;
  logic [15:0]       waddr;
  logic [WORD_W-1:0] wdata;
  logic              busy, done, err;
`ifdef MIX_W_LOADER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mix_w_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .err(err)
`ifdef MIX_W_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge. Owns all of its variables;
  // tests take snapshots and compare deltas.
  int                wr_total = 0;
  int                order_err = 0, data_err = 0, align_err = 0;
  int                hs_in_load = 0, wr_in_load = 0;
  int                last_addr = -1;
  logic [WORD_W-1:0] word0 = '0;
  logic [WORD_W-1:0] exp_w;

  always @(negedge clk) begin
    if (rst_n || start) begin
      hs_in_load = 0;
      wr_in_load = 0;
    end else begin
      if (we) begin
        if (int'(waddr) != wr_in_load) order_err++;
        if (hs_in_load % DATA_N != 0 || hs_in_load / DATA_N != wr_in_load + 1) align_err++;
        exp_w = '0;
        for (int k = 0; k < DATA_N; k++)
          exp_w[WORD_W-1-N_LEN*k -: N_LEN] = N_LEN'(int'(waddr) * DATA_N + k);
        if (wdata !== exp_w) data_err++;
        if (waddr == 16'd0) word0 = wdata;
        last_addr = int'(waddr);
        wr_total++;
        wr_in_load++;
      end
      if (s_valid && s_ready) hs_in_load++;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic stream(input int n, input int last_idx, input bit gaps);
    int  i = 0;
    int  cyc = 0;
    bit  h;
    bit  to = 0;
    while (i < n) begin
      s_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      s_data  = N_LEN'(i);
      s_last  = (i == last_idx);
      h = s_valid && s_ready;
      @(posedge clk); #1;
      if (h) i++;
      cyc++;
      if (cyc > 8000) begin to = 1; break; end
    end
    s_valid = 0;
    s_last  = 0;
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL stream_timeout: accepted %0d required %0d", i, n); end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1;
    wait_cyc(2);
    n_cmp++;
    if ({s_ready, we, busy, done, err} !== 5'b0 || waddr !== '0 || wdata !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy/we/busy/done/err=%b waddr=%h required all 0", {s_ready, we, busy, done, err}, waddr);
    end
    #1 rst_n = 0;
    wait_cyc(2);
    n_cmp++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_outputs: s_ready=%b busy=%b required 0 0", s_ready, busy);
    end
  endtask

  task automatic test_basic();
    int w0 = wr_total, o0 = order_err, d0 = data_err, a0 = align_err;
    pulse_start();
    n_cmp++;
    if (s_ready !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL basic_load_state: s_ready=%b busy=%b required 1 1", s_ready, busy);
    end
    stream(NELEM, NELEM - 1, 0);
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_status: done=%b err=%b rdy=%b busy=%b required 1 0 0 0", done, err, s_ready, busy);
    end
    n_cmp++;
    if (we !== 1'b1 || waddr !== 16'd107) begin
      n_bad++; $display("FAIL basic_final_write: we=%b waddr=%0d required 1 107", we, waddr);
    end
    wait_cyc(3);
    n_cmp++;
    if (wr_total - w0 != NWORD || last_addr != NWORD - 1) begin
      n_bad++; $display("FAIL basic_writes: count=%0d last=%0d required 108 107", wr_total - w0, last_addr);
    end
    n_cmp++;
    if (order_err != o0 || data_err != d0 || align_err != a0) begin
      n_bad++; $display("FAIL basic_order_data: order=%0d data=%0d align=%0d required 0 0 0", order_err - o0, data_err - d0, align_err - a0);
    end
    n_cmp++;
    if (word0[255:240] !== 16'h0000 || word0[15:0] !== 16'h000F) begin
      n_bad++; $display("FAIL basic_word0: msb=%h lsb=%h required 0000 000f", word0[255:240], word0[15:0]);
    end
  endtask

  task automatic test_gaps();
    int w0 = wr_total, o0 = order_err, d0 = data_err, a0 = align_err;
    pulse_start();
    n_cmp++;
    if (done !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL gaps_start_clear: done=%b err=%b required 0 0", done, err);
    end
    stream(NELEM, NELEM - 1, 1);
    wait_cyc(3);
    n_cmp++;
    if (wr_total - w0 != NWORD || order_err != o0 || data_err != d0 || align_err != a0) begin
      n_bad++;
      $display("FAIL gaps_writes: count=%0d order=%0d data=%0d align=%0d required 108 0 0 0", wr_total - w0, order_err - o0, data_err - d0, align_err - a0);
    end
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_bad++; $display("FAIL gaps_status: done=%b err=%b required 1 0", done, err);
    end
  endtask

  task automatic test_early_last();
    int w0 = wr_total, d0 = data_err;
    pulse_start();
    stream(20, 19, 0);
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b1 || s_ready !== 1'b0) begin
      n_bad++; $display("FAIL early_status: done=%b err=%b rdy=%b required 1 1 0", done, err, s_ready);
    end
    wait_cyc(5);
    n_cmp++;
    if (wr_total - w0 != 1 || last_addr != 0 || data_err != d0) begin
      n_bad++; $display("FAIL early_writes: count=%0d last=%0d data=%0d required 1 0 0", wr_total - w0, last_addr, data_err - d0);
    end
  endtask

  task automatic test_missing_last();
    int w0 = wr_total, o0 = order_err;
    pulse_start();
    stream(NELEM, -1, 0);
    wait_cyc(3);
    n_cmp++;
    if (wr_total - w0 != NWORD || order_err != o0 || last_addr != NWORD - 1) begin
      n_bad++; $display("FAIL missing_writes: count=%0d last=%0d required 108 107", wr_total - w0, last_addr);
    end
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b1) begin
      n_bad++; $display("FAIL missing_status: done=%b err=%b required 1 1", done, err);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_total, o0 = order_err, d0 = data_err;
    int w1;
    pulse_start();
    stream(50, -1, 0);
    rst_n = 1;
    #1;
    n_cmp++;
    if ({s_ready, we, busy, done, err} !== 5'b0 || waddr !== '0 || wdata !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: rdy/we/busy/done/err=%b waddr=%h required all 0", {s_ready, we, busy, done, err}, waddr);
    end
    wait_cyc(2);
    #1 rst_n = 0;
    wait_cyc(3);
    n_cmp++;
    if (wr_total - w0 != 3) begin
      n_bad++; $display("FAIL midreset_partial: writes=%0d required 3", wr_total - w0);
    end
    w1 = wr_total;
    pulse_start();
    stream(NELEM, NELEM - 1, 0);
    wait_cyc(3);
    n_cmp++;
    if (wr_total - w1 != NWORD || order_err != o0 || data_err != d0 || done !== 1'b1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_reload: count=%0d order=%0d data=%0d done=%b err=%b required 108 0 0 1 0", wr_total - w1, order_err - o0, data_err - d0, done, err);
    end
  endtask

`ifdef MIX_W_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    n_cmp++;
    if (checksum !== 32'h0) begin
      n_bad++; $display("FAIL checksum_clear: got %h required 00000000", checksum);
    end
    stream(NELEM, NELEM - 1, 0);
    wait_cyc(4);
    n_cmp++;
    if (checksum !== 32'h0016C4A0) begin
      n_bad++; $display("FAIL checksum_value: got %h required 0016c4a0", checksum);
    end
    pulse_start();
    stream(20, 19, 0);
    n_cmp++;
    // 0+1+...+19 = 190, dropped partial elements included
    if (checksum !== 32'd190) begin
      n_bad++; $display("FAIL checksum_partial: got %0d required 190", checksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_early_last();
    test_missing_last();
    test_reset_mid();
`ifdef MIX_W_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
